// File: rtl/cdu_phase_source.sv
// cdu_phase_source: 51.2 kHz phase reference, ISSIHI/CCDUZ generator and FAZ sequence monitor (monitor built only when CDU_PHASE_MON_EN is defined)
module cdu_phase_source #(
    parameter int CLK_DIV     = 1000,
    parameter int ISSI_PERIOD = 64,
    parameter int CCDUZ_LEN   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issi_en,
    input  logic       zero_req,
    input  logic       FAZ1HI,
    input  logic       FAZ2HI,
    input  logic       FAZ3HI,
    input  logic       FAZ4HI,
    input  logic       fault_clr,
    output logic       _51KPHI,
    output logic       ISSIHI,
    output logic       CCDUZ,
    output logic       zero_ack,
    output logic       fault,
    output logic [1:0] fault_code
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int PW = $clog2(ISSI_PERIOD);
    localparam int ZW = $clog2(CCDUZ_LEN + 1);
    localparam int SW = $clog2(8 * CLK_DIV + 1);

    typedef enum logic [1:0] {IDLE, ARM, ZERO, DONE} zstate_t;

    zstate_t state, state_nxt;
    logic [DW-1:0] div;
    logic [PW-1:0] per;
    logic [ZW-1:0] zcnt, zcnt_nxt;
    logic div_end, tick, per_end;

    assign div_end = div == DW'(CLK_DIV - 1);
    assign tick    = div_end && !_51KPHI;
    assign per_end = per == PW'(ISSI_PERIOD - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            per     <= PW'(ISSI_PERIOD - 1);
            _51KPHI <= 1'b0;
            ISSIHI  <= 1'b0;
        end else begin
            div <= div_end ? '0 : div + 1'b1;
            if (div_end) _51KPHI <= !_51KPHI;
            if (tick) begin
                per    <= per_end ? '0 : per + 1'b1;
                ISSIHI <= per_end && issi_en;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        zcnt_nxt  = '0;
        case (state)
            IDLE: state_nxt = zero_req ? ARM : IDLE;
            ARM:  state_nxt = !zero_req ? IDLE : (tick ? ZERO : ARM);
            ZERO: begin
                zcnt_nxt  = tick ? zcnt + 1'b1 : zcnt;
                state_nxt = (tick && zcnt == ZW'(CCDUZ_LEN - 1)) ? DONE : ZERO;
            end
            DONE: state_nxt = zero_req ? DONE : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            zcnt     <= '0;
            CCDUZ    <= 1'b0;
            zero_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            zcnt     <= zcnt_nxt;
            CCDUZ    <= state_nxt == ZERO;
            zero_ack <= state_nxt == DONE;
        end
    end

`ifdef CDU_PHASE_MON_EN
    logic [3:0] faz, cur, succ;
    logic [SW-1:0] stall;
    logic [1:0] cause;
    logic synced, single, multi, adv, stall_end;

    assign faz       = {FAZ4HI, FAZ3HI, FAZ2HI, FAZ1HI};
    assign succ      = {cur[2:0], cur[3]};
    assign single    = $onehot(faz);
    assign multi     = |faz && !single;
    assign adv       = faz == succ;
    assign stall_end = stall == SW'(8 * CLK_DIV - 1);
    assign cause     = multi ? 2'd1 : (single && faz != cur && !adv) ? 2'd2 : (stall_end && !adv) ? 2'd3 : 2'd0;

    // cur is one-hot so its successor is a rotate; first fault cause is latched
    always_ff @(posedge clk) begin
        if (rst || fault_clr) begin
            synced     <= 1'b0;
            cur        <= '0;
            stall      <= '0;
            fault      <= 1'b0;
            fault_code <= 2'd0;
        end else if (!synced) begin
            synced <= single;
            cur    <= faz;
            stall  <= '0;
        end else begin
            if (adv) cur <= succ;
            stall <= (adv || stall_end) ? '0 : stall + 1'b1;
            if (cause != 2'd0 && !fault) begin
                fault      <= 1'b1;
                fault_code <= cause;
            end
        end
    end
`else
    logic unused_mon;
    assign unused_mon = ^{FAZ1HI, FAZ2HI, FAZ3HI, FAZ4HI, fault_clr};
    assign fault      = 1'b0;
    assign fault_code = 2'd0;
`endif
endmodule

// File: tb/tb_cdu_phase_source.sv
// tb_cdu_phase_source: scoreboard bench with a timeline-based reference model for cdu_phase_source
module tb_cdu_phase_source;
    localparam int CD = 4;
    localparam int IP = 4;
    localparam int CL = 2;

    typedef struct packed {
        logic       phi;
        logic       issi;
        logic       ccduz;
        logic       ack;
        logic       flt;
        logic [1:0] code;
    } exp_t;

    logic       clk;
    logic       rst, issi_en, zero_req, fault_clr;
    logic [3:0] faz;
    logic       phi, issi, ccduz, zero_ack, fault;
    logic [1:0] fault_code;

    exp_t q[$];
    exp_t got;
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;

    int t, k, z_end, now, last, cur, mcode;
    bit m_issi, arm, zact, ack, synced, mflt;

    cdu_phase_source #(.CLK_DIV(CD), .ISSI_PERIOD(IP), .CCDUZ_LEN(CL)) dut (
        .clk(clk), .rst(rst), .issi_en(issi_en), .zero_req(zero_req),
        .FAZ1HI(faz[0]), .FAZ2HI(faz[1]), .FAZ3HI(faz[2]), .FAZ4HI(faz[3]),
        .fault_clr(fault_clr), ._51KPHI(phi), .ISSIHI(issi), .CCDUZ(ccduz),
        .zero_ack(zero_ack), .fault(fault), .fault_code(fault_code)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [1:0] act, logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Timeline model: phase from elapsed cycles, pulses from tick indices
    task automatic model();
        exp_t e;
        bit tick;
        int ones, fi, bad;
        now++;
        if (rst) begin
            t = 0; k = 0; m_issi = 0; arm = 0; zact = 0; ack = 0;
        end else begin
            t++;
            tick = (t % (2 * CD)) == CD;
            if (tick) begin
                k++;
                m_issi = ((k - 1) % IP == 0) && issi_en;
            end
            if (ack) ack = zero_req;
            else if (zact) begin
                if (tick && k == z_end) begin zact = 0; ack = 1; end
            end else if (arm) begin
                if (!zero_req) arm = 0;
                else if (tick) begin arm = 0; zact = 1; z_end = k + CL; end
            end else arm = zero_req;
        end
        ones = $countones(faz);
        fi = 0;
        for (int i = 0; i < 4; i++) if (faz[i]) fi = i + 1;
        bad = 0;
        if (rst || fault_clr) begin
            synced = 0; mflt = 0; mcode = 0;
        end else if (!synced) begin
            if (ones == 1) begin synced = 1; cur = fi; last = now; end
        end else begin
            if (ones > 1) bad = 1;
            else if (ones == 1 && fi == cur % 4 + 1) begin cur = fi; last = now; end
            else if (ones == 1 && fi != cur) bad = 2;
            else if (now - last == 8 * CD) bad = 3;
            if (bad != 0 && !mflt) begin mflt = 1; mcode = bad; end
        end
        e.phi   = ((t / CD) % 2) == 1;
        e.issi  = m_issi;
        e.ccduz = zact;
        e.ack   = ack;
`ifdef CDU_PHASE_MON_EN
        e.flt  = mflt;
        e.code = 2'(mcode);
`else
        e.flt  = 1'b0;
        e.code = 2'd0;
`endif
        q.push_back(e);
    endtask

    task automatic step();
        model();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                got = q.pop_front();
                chk("51KPHI", phi, got.phi);
                chk("ISSIHI", issi, got.issi);
                chk("CCDUZ", ccduz, got.ccduz);
                chk("zero_ack", zero_ack, got.ack);
                chk("fault", fault, got.flt);
                chk("fault_code", fault_code, got.code);
            end
        end
    end

    logic [3:0] pat [11] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h4, 4'h3};

    initial begin
        int ph, hold;
        rst = 1; issi_en = 0; zero_req = 0; fault_clr = 0; faz = '0;
        repeat (3) step();
        rst = 0; issi_en = 1;
        repeat (6) step();
        zero_req = 1;
        repeat (24) step();
        zero_req = 0;
        repeat (20) step();
        rst = 1; step(); rst = 0;
        repeat (5) step();
        zero_req = 1;
        repeat (2) step();
        zero_req = 0;
        repeat (20) step();
        rst = 1; step(); rst = 0;
        foreach (pat[i]) begin
            faz = pat[i];
            repeat (3) step();
        end
        faz = '0;
        fault_clr = 1; step(); fault_clr = 0;
        faz = 4'h2;
        repeat (40) step();
        fault_clr = 1; step(); fault_clr = 0;
        faz = '0;
        rst = 1; step(); rst = 0;
        zero_req = 1;
        repeat (15) step();
        rst = 1; step(); rst = 0;
        zero_req = 0;
        repeat (10) step();
        ph = 0; hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) issi_en = !issi_en;
            if ($urandom_range(0, 11) == 0) zero_req = !zero_req;
            if (hold == 0) begin
                ph = (ph + 1) % 4;
                hold = ($urandom_range(0, 19) == 0) ? 40 : $urandom_range(1, 8);
            end
            hold--;
            faz = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'(1 << ph);
            if ($urandom_range(0, 199) == 0) faz = 4'($urandom);
            fault_clr = $urandom_range(0, 99) == 0;
            rst = $urandom_range(0, 499) == 0;
            step();
        end
        #1 done = 1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdu_phase_source.md
# cdu_phase_source

AGC-side source for the CDU digital-mode timing chain. It generates the 51.2 kHz phase reference `_51KPHI`, the periodic ISS interrogate pulse `ISSIHI` and the `CCDUZ` zero command behind a level handshake. It also checks the phase drives `FAZ1HI`..`FAZ4HI` that the CDU decodes from that reference. In benches it drives the CDU digital-mode block and closes the loop on that block's phase outputs.

## Interface
- `CLK_DIV`, 1000: `clk` cycles per half-period of `_51KPHI`; must be ≥2. At 102.4 MHz this gives 51.2 kHz.
- `ISSI_PERIOD`, 64: `_51KPHI` periods between `ISSIHI` pulses; must be ≥2. The default gives 800 Hz.
- `CCDUZ_LEN`, 16: `_51KPHI` periods for which `CCDUZ` is held; must be ≥1.
- `clk`  in  1  sole clock. All logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `issi_en`  in  1  enables `ISSIHI` generation.
- `zero_req`  in  1  level request for a CDU zero.
- `FAZ1HI`, `FAZ2HI`, `FAZ3HI`, `FAZ4HI`  in  1 each  phase drives returned from the CDU.
- `fault_clr`  in  1  one-cycle pulse that clears the sticky fault.
- `_51KPHI`  out  1  phase reference square wave.
- `ISSIHI`  out  1  ISS interrogate pulse.
- `CCDUZ`  out  1  CDU zero command.
- `zero_ack`  out  1  handshake acknowledge for `zero_req`.
- `fault`  out  1  sticky phase-sequence fault.
- `fault_code`  out  2  cause of the first fault: 0 none, 1 overlap, 2 out of order, 3 stall.

## Operation
- **Divider.** Counter `div` runs 0..`CLK_DIV`-1 and wraps. At the terminal count `_51KPHI` toggles. A 0→1 toggle is a "period tick".
- **Period counter.** `per` runs 0..`ISSI_PERIOD`-1 and advances on each period tick.
- **ISSIHI.** Asserts on the period tick where `per` wraps to 0, if `issi_en`=1 at that edge. It holds for exactly 2·`CLK_DIV` cycles. Dropping `issi_en` mid-pulse does not truncate the pulse.
- **Zero FSM, IDLE→ARM.** Transitions when `zero_req`=1.
- **Zero FSM, ARM.** On the next period tick go to ZERO. If `zero_req`=0 before that tick, return to IDLE with no pulse.
- **Zero FSM, ZERO.** `CCDUZ`=1 for `CCDUZ_LEN` period ticks, then go to DONE. Dropping `zero_req` here does not truncate the pulse.
- **Zero FSM, DONE.** `zero_ack`=1 while in DONE. Return to IDLE on the first cycle `zero_req`=0. If `zero_req` is already 0 on entry, `zero_ack` is high for exactly 1 cycle.
- **Re-request.** `zero_req` held high through DONE→IDLE does not re-trigger. A new request needs a low then a high.
- **Monitor sync.** After reset, the monitor is unsynced until it sees exactly one FAZ input high. That phase becomes `cur`.
- **Monitor allowed inputs.** All-low (gap), `cur`, or successor(`cur`) with 4→1 wrap. The successor updates `cur`.
- **Monitor fault causes.**
  - Two or more FAZ inputs high: code 1.
  - Any other single phase: code 2.
  - No change of `cur` for 8·`CLK_DIV` cycles while synced: code 3.
- **Fault handling.**
  - `fault` is sticky and `fault_code` holds the first cause; later faults do not overwrite it.
  - `fault_clr` zeroes both and returns the monitor to unsynced.
  - `fault_clr` on the same cycle as a new fault: clear wins.

## Timing
- **Reset values.** All outputs are 0: `_51KPHI`, `ISSIHI`, `CCDUZ`, `zero_ack`, `fault`, `fault_code`. Internally, `div`=0, `per`=`ISSI_PERIOD`-1, zero FSM in IDLE, monitor unsynced.
- **First edges after reset.**
  - The first `_51KPHI` rise is on the clock edge after `CLK_DIV` cycles out of reset.
  - That first tick wraps `per` to 0, so the first `ISSIHI` coincides with the first `_51KPHI` rise when `issi_en`=1.
- **Output alignment.** `ISSIHI` and `CCDUZ` assert and deassert on the same clock edge as a `_51KPHI` rise.
- **Registered outputs.** All outputs are registered; there is no combinational path from input to output.
- **Zero handshake latency.** The `zero_req` rise is sampled at edge N; the state is ARM from N+1. `CCDUZ` rises at the first period tick at or after N+1.
- **Fault latency.** `fault` rises 1 cycle after the offending FAZ sample.
- **Reset mid-operation.** `rst` at any cycle forces all outputs low at the next edge. This includes mid-`CCDUZ`, mid-`ISSIHI` and DONE; no pulse resumes.
- **Widths.** `div` is $clog2(`CLK_DIV`) bits, `per` is $clog2(`ISSI_PERIOD`) bits, the stall counter is $clog2(8·`CLK_DIV`+1) bits. All counters are unsigned and wrap explicitly at their terminal count, never by overflow.

## Configuration
- **`CDU_PHASE_MON_EN` defined.** The monitor is built as described.
- **`CDU_PHASE_MON_EN` undefined.** No monitor logic; FAZ inputs and `fault_clr` are ignored; `fault`=0 and `fault_code`=0 always. Generator and zero FSM behaviour is unchanged.

## Test plan
All scenarios use `CLK_DIV`=4, `ISSI_PERIOD`=4, `CCDUZ_LEN`=2.
- **Reset release, `issi_en`=1.** `_51KPHI` rises at cycle 4 with period 8. `ISSIHI` is high cycles 4–11, then again 36–43.
- **Zero request.** Raise `zero_req` at cycle 6 and drop it at cycle 30. `CCDUZ` is high cycles 12–27; `zero_ack` is high cycles 28–30; state is IDLE at 31.
- **Aborted request.** Raise `zero_req` at cycle 5 and drop it at cycle 7. No `CCDUZ`, no `zero_ack`.
- **Phase faults.** Drive FAZ 1,2,3,4,1 with gaps: no fault. Then drive FAZ3 after FAZ1: `fault`=1, code 2. A later overlap keeps code 2. `fault_clr` clears both.
- **Stall.** Hold FAZ2 for 33 cycles: `fault`=1, code 3 at the 33rd cycle.
- **Reset mid-pulse.** Assert `rst` during `CCDUZ`: all outputs are 0 the next cycle. The macro-undefined build keeps `fault`=0 under overlap stimulus.
